// File: rtl/graphics_pkg.sv
// Shared screen geometry, vertex record layout and reader state encoding
// for the graphics datapath.
package graphics_pkg;

    localparam int unsigned SCREEN_W         = 160;
    localparam int unsigned SCREEN_H         = 120;
    localparam int unsigned WORDS_PER_VERTEX = 3;
    localparam int unsigned WORDS_PER_TRI    = 9;
    localparam int unsigned FRAC_BITS        = 16;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StEmit0,
        StEmit1,
        StEmit2,
        StFin
    } reader_state_t;

endpackage

// File: rtl/q16_to_pixel.sv
// Signed Q16.16 to clamped integer pixel coordinate in 0..MAX-1; integer part
// is the floor of the fixed-point value.
module q16_to_pixel
    import graphics_pkg::*;
#(
    parameter int unsigned MAX = 160,
    parameter int unsigned W   = 8
) (
    input  logic signed [31:0] q,
    output logic [W-1:0]       pix
);

    logic [31-FRAC_BITS:0] int_part;
    logic                  unused_frac;

    assign int_part    = q[31:FRAC_BITS];
    assign unused_frac = ^q[FRAC_BITS-1:0];

    always_comb begin
        if (int_part[31-FRAC_BITS]) begin
            pix = '0;
        end else if (int_part >= (32-FRAC_BITS)'(MAX)) begin
            pix = W'(MAX - 1);
        end else begin
            pix = int_part[W-1:0];
        end
    end

endmodule

// File: rtl/mvp_vertex_reader.sv
// Reads transformed triangles out of the mvp_output RAM and streams each
// triangle's three edges as clamped pixel segments to the line rasteriser.
module mvp_vertex_reader #(
    parameter int unsigned RD_LAT   = 2,
    parameter int unsigned MAX_TRI  = 14,
    parameter int unsigned SCREEN_W = graphics_pkg::SCREEN_W,
    parameter int unsigned SCREEN_H = graphics_pkg::SCREEN_H
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] count,
    output logic        done,
    output logic [31:0] mem_read_addr,
    input  logic [31:0] mem_read_data,
    output logic        line_valid,
    input  logic        line_ready,
    output logic [7:0]  x0,
    output logic [6:0]  y0,
    output logic [7:0]  x1,
    output logic [6:0]  y1
);

    import graphics_pkg::*;

    localparam int unsigned TW = $clog2(MAX_TRI + 1);
    localparam int unsigned CW = $clog2(WORDS_PER_TRI + RD_LAT);
    localparam logic [CW-1:0] LastIssue = CW'(WORDS_PER_TRI - 1);
    localparam logic [CW-1:0] LastCyc   = CW'(WORDS_PER_TRI - 1 + RD_LAT);

    reader_state_t   state_q, state_d;
    logic [TW-1:0]   tri_left_q, tri_left_d;
    logic [6:0]      ptr_q, ptr_d, ptr_next;
    logic [6:0]      addr_q, addr_d;
    logic [CW-1:0]   cyc_q, cyc_d;
    logic [3:0]      cap_q, cap_d;
    logic [31:0]     vx_q [3];
    logic [31:0]     vx_d [3];
    logic [31:0]     vy_q [3];
    logic [31:0]     vy_d [3];
    logic            valid_q, valid_d;
    logic            done_q, done_d;
    logic            hs;
    logic [31:0]     ax, ay, bx, by;

    assign hs            = valid_q && line_ready;
    assign ptr_next      = ptr_q + 7'(WORDS_PER_TRI);
    assign mem_read_addr = {25'd0, addr_q};
    assign line_valid    = valid_q;
    assign done          = done_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            tri_left_q <= '0;
            ptr_q      <= '0;
            addr_q     <= '0;
            cyc_q      <= '0;
            cap_q      <= '0;
            vx_q       <= '{default: '0};
            vy_q       <= '{default: '0};
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tri_left_q <= tri_left_d;
            ptr_q      <= ptr_d;
            addr_q     <= addr_d;
            cyc_q      <= cyc_d;
            cap_q      <= cap_d;
            vx_q       <= vx_d;
            vy_q       <= vy_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tri_left_d = tri_left_q;
        ptr_d      = ptr_q;
        addr_d     = addr_q;
        cyc_d      = cyc_q;
        cap_d      = cap_q;
        vx_d       = vx_q;
        vy_d       = vy_q;
        valid_d    = 1'b0;
        done_d     = done_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    done_d = 1'b0;
                    if (count > 32'(MAX_TRI)) begin
                        tri_left_d = TW'(MAX_TRI);
                    end else begin
                        tri_left_d = count[TW-1:0];
                    end
                    if (count == 32'd0) begin
                        state_d = StFin;
                    end else begin
                        ptr_d   = '0;
                        addr_d  = '0;
                        cyc_d   = '0;
                        cap_d   = '0;
                        state_d = StFetch;
                    end
                end
            end
            StFetch: begin
                cyc_d = cyc_q + CW'(1);
                if (cyc_q < LastIssue) begin
                    addr_d = addr_q + 7'd1;
                end
                // Data for the address issued RD_LAT cycles ago is on the bus now.
                if (cyc_q >= CW'(RD_LAT)) begin
                    cap_d = cap_q + 4'd1;
                    for (int v = 0; v < 3; v++) begin
                        if (cap_q == 4'(v * WORDS_PER_VERTEX)) vx_d[v] = mem_read_data;
                        if (cap_q == 4'(v * WORDS_PER_VERTEX + 1)) vy_d[v] = mem_read_data;
                    end
                end
                if (cyc_q == LastCyc) begin
                    state_d = StEmit0;
                    valid_d = 1'b1;
                end
            end
            StEmit0: begin
                valid_d = 1'b1;
                if (hs) state_d = StEmit1;
            end
            StEmit1: begin
                valid_d = 1'b1;
                if (hs) state_d = StEmit2;
            end
            StEmit2: begin
                if (hs) begin
                    tri_left_d = tri_left_q - TW'(1);
                    if (tri_left_q == TW'(1)) begin
                        state_d = StFin;
                    end else begin
                        ptr_d   = ptr_next;
                        addr_d  = ptr_next;
                        cyc_d   = '0;
                        cap_d   = '0;
                        state_d = StFetch;
                    end
                end else begin
                    valid_d = 1'b1;
                end
            end
            StFin: begin
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Edge endpoint selection; vertex registers are frozen outside FETCH, so
    // endpoints hold steady across a stall.
    always_comb begin
        ax = vx_q[0];
        ay = vy_q[0];
        bx = vx_q[1];
        by = vy_q[1];
        case (state_q)
            StEmit1: begin
                ax = vx_q[1];
                ay = vy_q[1];
                bx = vx_q[2];
                by = vy_q[2];
            end
            StEmit2: begin
                ax = vx_q[2];
                ay = vy_q[2];
                bx = vx_q[0];
                by = vy_q[0];
            end
            default: ;
        endcase
    end

    q16_to_pixel #(.MAX(SCREEN_W), .W(8)) u_x0 (.q(ax), .pix(x0));
    q16_to_pixel #(.MAX(SCREEN_H), .W(7)) u_y0 (.q(ay), .pix(y0));
    q16_to_pixel #(.MAX(SCREEN_W), .W(8)) u_x1 (.q(bx), .pix(x1));
    q16_to_pixel #(.MAX(SCREEN_H), .W(7)) u_y1 (.q(by), .pix(y1));

endmodule

// File: tb/tb_mvp_vertex_reader.sv
// Directed bench for mvp_vertex_reader with a two-cycle-latency RAM model.
module tb_mvp_vertex_reader;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] count = 32'd0;
    logic        done;
    logic [31:0] mem_read_addr;
    logic [31:0] mem_read_data;
    logic        line_valid;
    logic        line_ready = 1'b0;
    logic [7:0]  x0, x1;
    logic [6:0]  y0, y1;

    logic [31:0] ram [128];
    logic [6:0]  addr_r;
    logic [31:0] data_r;

    int tests = 0;
    int fails = 0;
    int cyc_cnt = 0;
    int t0 = 0;
    int first_valid = 0;
    int last_hs = 0;
    logic [29:0] exp_q [$];

    mvp_vertex_reader dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .count         (count),
        .done          (done),
        .mem_read_addr (mem_read_addr),
        .mem_read_data (mem_read_data),
        .line_valid    (line_valid),
        .line_ready    (line_ready),
        .x0            (x0),
        .y0            (y0),
        .x1            (x1),
        .y1            (y1)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        cyc_cnt <= cyc_cnt + 1;
        addr_r  <= mem_read_addr[6:0];
        data_r  <= ram[addr_r];
    end
    assign mem_read_data = data_r;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [29:0] seg(input int ax, input int ay, input int bx, input int by);
        return {8'(ax), 7'(ay), 8'(bx), 7'(by)};
    endfunction

    task automatic push_tri(input int ax, input int ay, input int bx, input int by,
                            input int cx, input int cy);
        exp_q.push_back(seg(ax, ay, bx, by));
        exp_q.push_back(seg(bx, by, cx, cy));
        exp_q.push_back(seg(cx, cy, ax, ay));
    endtask

    function automatic int tri_x(input int t, input int v);
        return t * 10 + v * 3;
    endfunction

    function automatic int tri_y(input int t, input int v);
        return t * 8 + v * 2 + 1;
    endfunction

    function automatic logic [31:0] tri_word(input int t, input int w);
        int v = w / 3;
        case (w % 3)
            0:       return (32'(tri_x(t, v)) << 16) | 32'h4000;
            1:       return 32'(tri_y(t, v)) << 16;
            default: return 32'hDEAD_0000 + 32'(t);
        endcase
    endfunction

    task automatic push_grid_tri(input int t);
        push_tri(tri_x(t, 0), tri_y(t, 0), tri_x(t, 1), tri_y(t, 1), tri_x(t, 2), tri_y(t, 2));
    endtask

    task automatic load_single();
        ram[0] = 32'h000A_8000; ram[1] = 32'h0014_0000; ram[2] = 32'h0001_0000;
        ram[3] = 32'h001E_0000; ram[4] = 32'h0028_E666; ram[5] = 32'h0002_0000;
        ram[6] = 32'hFFFD_0000; ram[7] = 32'h00C8_0000; ram[8] = 32'h0003_0000;
    endtask

    // Caller sits on a negedge; returns on the negedge of cycle 1 of the pass.
    task automatic pulse_start(input logic [31:0] n);
        start = 1'b1;
        count = n;
        t0    = cyc_cnt;
        @(negedge clock);
        start = 1'b0;
        count = 32'hFFFF_FFFF;
    endtask

    // Consumes exp_q; every valid cycle (handshake or stall) must show the head segment.
    task automatic expect_segs(input bit bp, input string tag);
        int n = exp_q.size();
        int got = 0;
        int k = 0;
        first_valid = -1;
        while (got < n) begin
            if (bp) line_ready = ((k / 3) % 2) == 1;
            if (line_valid) begin
                if (first_valid < 0) first_valid = cyc_cnt - t0;
                check($sformatf("%s seg%0d", tag, got), 32'({x0, y0, x1, y1}), 32'(exp_q[0]));
                if (line_ready) begin
                    last_hs = cyc_cnt - t0;
                    void'(exp_q.pop_front());
                    got++;
                end
            end
            if (got < n) begin
                if (k >= 1000) begin
                    check($sformatf("%s segments before timeout", tag), got, n);
                    exp_q.delete();
                    break;
                end
                @(negedge clock);
                k++;
            end
        end
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        int extra = 0;
        @(negedge clock);
        while (done !== 1'b1 && k < 40) begin
            if (line_valid) extra++;
            @(negedge clock);
            k++;
        end
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " no extra segment"}, extra, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] a_before;
        bit          saw_valid;
        bit          addr_moved;

        line_ready = 1'b1;
        repeat (3) @(negedge clock);
        check("rst done", 32'(done), 32'd0);
        check("rst line_valid", 32'(line_valid), 32'd0);
        check("rst mem_read_addr", mem_read_addr, 32'd0);
        check("rst endpoints", 32'({x0, y0, x1, y1}), 32'd0);
        reset = 1'b1;
        @(negedge clock);

        // Single triangle, ready held high: valid at cycle 12, done at cycle 16.
        load_single();
        push_tri(10, 20, 30, 40, 0, 119);
        pulse_start(32'd1);
        check("single addr c1", mem_read_addr, 32'd0);
        expect_segs(1'b0, "single");
        check("single first valid cycle", first_valid, 12);
        check("single last handshake cycle", last_hs, 14);
        @(negedge clock);
        check("single done c15", 32'(done), 32'd0);
        @(negedge clock);
        check("single done c16", 32'(done), 32'd1);
        check("single last addr", mem_read_addr, 32'd8);

        // Zero count: FIN then IDLE, no reads, no segments.
        @(negedge clock);
        a_before   = mem_read_addr;
        saw_valid  = 1'b0;
        addr_moved = 1'b0;
        pulse_start(32'd0);
        check("zero done c1", 32'(done), 32'd0);
        saw_valid  = saw_valid | line_valid;
        addr_moved = addr_moved | (mem_read_addr != a_before);
        @(negedge clock);
        check("zero done c2", 32'(done), 32'd1);
        repeat (4) begin
            saw_valid  = saw_valid | line_valid;
            addr_moved = addr_moved | (mem_read_addr != a_before);
            @(negedge clock);
        end
        check("zero no valid", 32'(saw_valid), 32'd0);
        check("zero no addr change", 32'(addr_moved), 32'd0);

        // Backpressure: ready toggles every 3 cycles.
        push_tri(10, 20, 30, 40, 0, 119);
        pulse_start(32'd1);
        expect_segs(1'b1, "bp");
        wait_done("bp");

        // Count above the RAM capacity clamps to 14 triangles.
        line_ready = 1'b1;
        for (int t = 0; t < 14; t++) begin
            for (int w = 0; w < 9; w++) ram[t * 9 + w] = tri_word(t, w);
            push_grid_tri(t);
        end
        ram[126] = 32'h7FFF_0000;
        ram[127] = 32'h7FFF_0000;
        @(negedge clock);
        pulse_start(32'd20);
        expect_segs(1'b0, "clamp");
        wait_done("clamp");
        check("clamp last addr", mem_read_addr, 32'd125);

        // A second start during FETCH is ignored.
        push_grid_tri(0);
        push_grid_tri(1);
        pulse_start(32'd2);
        repeat (2) @(negedge clock);
        start = 1'b1;
        count = 32'd5;
        @(negedge clock);
        start = 1'b0;
        expect_segs(1'b0, "busy");
        wait_done("busy");

        // Reset during EMIT1 of the second triangle, then restart at address 0.
        push_grid_tri(0);
        exp_q.push_back(seg(tri_x(1, 0), tri_y(1, 0), tri_x(1, 1), tri_y(1, 1)));
        pulse_start(32'd3);
        expect_segs(1'b0, "prereset");
        @(negedge clock);
        check("prereset emit1 valid", 32'(line_valid), 32'd1);
        reset = 1'b0;
        #1;
        check("midreset line_valid", 32'(line_valid), 32'd0);
        check("midreset done", 32'(done), 32'd0);
        check("midreset addr", mem_read_addr, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        // Boundary vertices: (160,120) (-0.5,119.75) (159.99,0).
        ram[0] = 32'h00A0_0000; ram[1] = 32'h0078_0000; ram[2] = 32'h0;
        ram[3] = 32'hFFFF_8000; ram[4] = 32'h0077_C000; ram[5] = 32'h0;
        ram[6] = 32'h009F_FD70; ram[7] = 32'h0000_0000; ram[8] = 32'h0;
        push_tri(159, 119, 0, 119, 159, 0);
        @(negedge clock);
        pulse_start(32'd1);
        check("restart addr c1", mem_read_addr, 32'd0);
        @(negedge clock);
        check("restart addr c2", mem_read_addr, 32'd1);
        expect_segs(1'b0, "restart");
        wait_done("restart");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
